mod241_chunk_streamer: RTL and testbench

- Transmit side of the 6-bit chunk interface consumed by the mod-241 LUT_6 residue tables.
- Accepts one 500-bit binary operand through a valid/ready handshake.
- Emits the operand as an ordered stream of 6-bit chunks. Each chunk carries its chunk index, and a last flag marks the final chunk, so the downstream LUT bank and accumulator can select the weight 2^(6*idx) mod 241.
- Sits between the operand source and the forward-conversion datapath.

---
 rtl/mod241_pkg.sv | 28 ++
 rtl/mod241_next_chunk_pe.sv | 28 ++
 rtl/mod241_chunk_streamer.sv | 123 ++++++++++++
 tb/tb_mod241_chunk_streamer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod241_pkg.sv
// Shared constants and types for the mod-241 chunk streamer.
// The streamer cuts a 500-bit operand into 84 six-bit chunks, one per
// LUT_6 residue-table lookup.
package mod241_pkg;

  localparam int OPERAND_W       = 500;
  localparam int CHUNK_W         = 6;
  localparam int NUM_CHUNKS      = (OPERAND_W + CHUNK_W - 1) / CHUNK_W;  // 84
  localparam int IDX_W           = 7;
  localparam int LAST_IDX        = NUM_CHUNKS - 1;                       // 83
  localparam int LAST_CHUNK_BITS = OPERAND_W - LAST_IDX * CHUNK_W;       // 2
  localparam int PAD_W           = NUM_CHUNKS * CHUNK_W;                 // 504

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Widen an operand to a whole number of chunks. The upper chunk keeps
  // only LAST_CHUNK_BITS real bits; the rest are forced to zero.
  function automatic logic [PAD_W-1:0] pad_operand(input logic [OPERAND_W-1:0] op);
    return {{(CHUNK_W - LAST_CHUNK_BITS){1'b0}}, op};
  endfunction

endpackage

// File: rtl/mod241_next_chunk_pe.sv
// Priority encoder: lowest set mask bit above from_idx (or at from_idx when
// inclusive=1). Falls back to LAST_IDX so the stream always ends on the
// last chunk.
module mod241_next_chunk_pe
  import mod241_pkg::*;
(
  input  logic [NUM_CHUNKS-1:0] mask,
  input  idx_t                  from_idx,
  input  logic                  inclusive,
  output idx_t                  next_idx
);

  logic [NUM_CHUNKS-1:0] cand;

  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_cand
    assign cand[gi] = mask[gi] &
                      ((idx_t'(gi) > from_idx) | (inclusive & (idx_t'(gi) == from_idx)));
  end

  // Scan from the top down so the lowest candidate wins.
  always_comb begin
    next_idx = idx_t'(LAST_IDX);
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      if (cand[i]) next_idx = idx_t'(i);
    end
  end

endmodule

// File: rtl/mod241_chunk_streamer.sv
// Transmit side of the 6-bit chunk interface feeding the mod-241 LUT_6 bank.
// Takes one 500-bit operand over valid/ready and plays it out as indexed
// 6-bit chunks, flagging the final chunk with out_last.
// Optional build macro MOD241_ZERO_SKIP_EN: all-zero chunks are skipped
// (they add nothing to the residue); chunk 83 is always sent.
module mod241_chunk_streamer
  import mod241_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHUNK_W-1:0]   out_chunk,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy
);

  state_t               state_q;
  logic [OPERAND_W-1:0] op_q;
  idx_t                 idx_q;
  logic                 in_ready_q;
  idx_t                 first_idx;
  idx_t                 next_idx;
  logic [PAD_W-1:0]     op_pad;
  chunk_t               chunks [NUM_CHUNKS];
  logic                 accept;
  logic                 at_last;

  assign accept  = (state_q == IDLE) && in_valid && in_ready_q;
  assign at_last = (idx_q == idx_t'(LAST_IDX));

  // Slice the held operand into its chunk lanes.
  assign op_pad = pad_operand(op_q);
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
    assign chunks[gi] = op_pad[gi*CHUNK_W +: CHUNK_W];
  end

`ifdef MOD241_ZERO_SKIP_EN
  logic [PAD_W-1:0]      in_pad;
  logic [NUM_CHUNKS-1:0] in_mask;
  logic [NUM_CHUNKS-1:0] mask_q;

  assign in_pad = pad_operand(in_data);
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_mask
    assign in_mask[gi] = |in_pad[gi*CHUNK_W +: CHUNK_W];
  end

  mod241_next_chunk_pe u_first_pe (
    .mask      (in_mask),
    .from_idx  (idx_t'(0)),
    .inclusive (1'b1),
    .next_idx  (first_idx)
  );

  mod241_next_chunk_pe u_next_pe (
    .mask      (mask_q),
    .from_idx  (idx_q),
    .inclusive (1'b0),
    .next_idx  (next_idx)
  );

  // Capture the nonzero-chunk mask alongside the operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= in_mask;
    end
  end
`else
  assign first_idx = idx_t'(0);
  assign next_idx  = idx_q + idx_t'(1);
`endif

  // Two-state handshake FSM: accept in IDLE, play chunks out in STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= in_data;
            idx_q      <= first_idx;
            state_q    <= STREAM;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (at_last) begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
            end else begin
              idx_q <= next_idx;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = (state_q == STREAM);
  assign out_valid = busy;
  assign out_idx   = idx_q;
  assign out_last  = busy && at_last;
  assign out_chunk = busy ? chunks[idx_q] : '0;

endmodule

// File: tb/tb_mod241_chunk_streamer.sv
// Self-checking bench for mod241_chunk_streamer: expected beats are queued
// when an operand is offered and compared as the DUT emits them.
module tb_mod241_chunk_streamer;

  localparam int OW = 500;
  localparam int NC = 84;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [5:0]    out_chunk;
  logic [6:0]    out_idx;
  logic          out_last;
  logic          busy;

  mod241_chunk_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chunk (out_chunk),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] idx;
    logic [5:0] chunk;
    logic       last;
  } beat_t;

  typedef struct {
    logic [OW-1:0] op;
    int            res;
    int            nbeats;
  } opexp_t;

  beat_t      exp_q[$];
  opexp_t     opx_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ready_mode = 1;
  int         weight [NC];
  logic [503:0] rx = '0;
  int         sum = 0;
  int         beat_cnt = 0;
  int         n_ops = 0;
  beat_t      e_b;
  opexp_t     e_o;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int residue(input logic [OW-1:0] op);
    int r = 0;
    for (int i = OW - 1; i >= 0; i--) r = (r * 2 + int'(op[i])) % 241;
    return r;
  endfunction

  function automatic logic [OW-1:0] rand_op();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    return t[OW-1:0];
  endfunction

  task automatic push_op(input logic [OW-1:0] op, output int nb);
    logic [503:0] p;
    beat_t        b;
    p  = {4'b0, op};
    nb = 0;
    for (int i = 0; i < NC; i++) begin
      b.idx   = 7'(i);
      b.chunk = p[i*6 +: 6];
      b.last  = (i == NC - 1);
`ifdef MOD241_ZERO_SKIP_EN
      if (b.chunk != 6'd0 || b.last) begin
        exp_q.push_back(b);
        nb++;
      end
`else
      exp_q.push_back(b);
      nb++;
`endif
    end
    opx_q.push_back('{op, residue(op), nb});
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout_in_ready", 0, 1);
  endtask

  task automatic send(input logic [OW-1:0] op, output int nb, output int c_acc);
    bit ok;
    wait_ready(ok);
    in_valid = 1'b1;
    in_data  = op;
    push_op(op, nb);
    @(posedge clk);
    #1;
    c_acc    = cyc;
    in_valid = 1'b0;
    @(negedge clk);
    check("first_beat_latency", out_valid, 1);
    check("busy_after_accept", busy, 1);
    check("in_ready_low_streaming", in_ready, 0);
  endtask

  task automatic drain(input int nb, input int c_acc, input bit timed);
    bit ok;
    wait_ready(ok);
    if (timed) check("beat_cycles", cyc - c_acc, nb);
    check("queue_empty", exp_q.size(), 0);
  endtask

  // Cycle counter for latency/throughput checks.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer: always ready, or a 50% random stall pattern.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (ready_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor: every valid beat (stalled or not) must match the queue head.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 1, 0);
      end else begin
        e_b = exp_q[0];
        check("out_idx", out_idx, e_b.idx);
        check("out_chunk", out_chunk, e_b.chunk);
        check("out_last", out_last, e_b.last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          rx[int'(out_idx)*6 +: 6] = out_chunk;
          sum = (sum + int'(out_chunk) * weight[out_idx]) % 241;
          beat_cnt++;
          if (out_last) begin
            if (opx_q.size() == 0) begin
              check("operand_missing", 1, 0);
            end else begin
              e_o = opx_q.pop_front();
              check("reassembled", rx[OW-1:0], e_o.op);
              check("lut_residue", sum, e_o.res);
              check("beat_count", beat_cnt, e_o.nbeats);
              $display("operand %0d: beats=%0d residue=%0d", n_ops, beat_cnt, sum);
            end
            n_ops++;
            rx = '0;
            sum = 0;
            beat_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "global timeout");
  end

  initial begin
    int            nb, nb2, c;
    bit            ok, found;
    logic [OW-1:0] op, op_b;

    weight[0] = 1;
    for (int i = 1; i < NC; i++) weight[i] = (weight[i-1] * 64) % 241;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_chunk", out_chunk, 0);
    check("rst_out_last", out_last, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    // Single set bit, full throughput.
    ready_mode = 1;
    send(500'd1, nb, c);
    drain(nb, c, 1);

    // All ones: top chunk carries only two bits.
    send({OW{1'b1}}, nb, c);
    drain(nb, c, 1);

    // Bits 0 and 300.
    op = '0;
    op[0] = 1'b1;
    op[300] = 1'b1;
    send(op, nb, c);
    drain(nb, c, 1);

    // Zero operand.
    send('0, nb, c);
    drain(nb, c, 1);

    // Random operands under random backpressure.
    ready_mode = 0;
    for (int k = 0; k < 3; k++) begin
      send(rand_op(), nb, c);
      drain(nb, c, 0);
    end
    ready_mode = 1;

    // Second operand offered during STREAM must wait for IDLE.
    op   = rand_op();
    op_b = rand_op();
    send(op, nb, c);
    in_valid = 1'b1;
    in_data  = op_b;
    push_op(op_b, nb2);
    repeat (10) @(negedge clk);
    check("in_ready_held_low", in_ready, 0);
    wait_ready(ok);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(nb2, 0, 0);

    // Asynchronous reset in mid-stream.
    send(rand_op(), nb, c);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_idx >= 7'd40) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("timeout_idx40", 0, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_idx", out_idx, 0);
    check("abort_out_last", out_last, 0);
    check("abort_in_ready", in_ready, 0);
    exp_q.delete();
    opx_q.delete();
    rx = '0;
    sum = 0;
    beat_cnt = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_abort", in_ready, 1);
    op = rand_op();
    send(op, nb, c);
    drain(nb, c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
